// File: rtl/udp_rx_dispatch.sv
// -----------------------------------------------------------------------------
// udp_rx_dispatch
//
// Buffers UDP payloads from the receiver into two 2048-byte ping-pong slots
// and dispatches each complete, good frame to one of NCH consumer channels.
// Channel k listens on destination port PORT_BASE+k. Frames for unknown
// ports, bad frames, oversize frames and frames arriving while both slots
// are full are discarded without stalling the receiver.
//
// Optional feature (macro UDP_RX_DISPATCH_STATS_EN):
//   defined   -> drop_cnt is a saturating count of discarded frames
//   undefined -> drop_cnt is tied to zero, no counter register exists
//
// Ports
//   c         clock, all logic on the rising edge
//   rst       asynchronous active-high reset
//   udp_d     payload byte from the UDP receiver
//   udp_dv    udp_d valid
//   udp_last  frame passed FCS/length checks (strobe, coincides with rx_end)
//   rx_end    end-of-frame strobe for every frame
//   udp_port  destination port, stable from first udp_dv until rx_end
//   out_rdy   per-channel ready from the consumers
//   out_d     dispatched byte
//   out_dv    out_d valid
//   out_last  out_d is the final byte of its packet
//   out_ch    destination channel of out_d
//   drop_cnt  number of discarded frames
// -----------------------------------------------------------------------------
module udp_rx_dispatch #(
    parameter logic [15:0] PORT_BASE = 16'd11300,
    parameter int          NCH       = 4
) (
    input  logic           c,
    input  logic           rst,
    input  logic [7:0]     udp_d,
    input  logic           udp_dv,
    input  logic           udp_last,
    input  logic           rx_end,
    input  logic [15:0]    udp_port,
    input  logic [NCH-1:0] out_rdy,
    output logic [7:0]     out_d,
    output logic           out_dv,
    output logic           out_last,
    output logic [1:0]     out_ch,
    output logic [15:0]    drop_cnt
);

    localparam int DATA_W = 8;
    localparam int AW     = 11;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_SEND}         r_state_t;

    // Slot storage and bookkeeping
    logic [DATA_W-1:0] ram [2][2**AW];
    logic [1:0]        full;
    logic [AW-1:0]     slot_len [2];
    logic [1:0]        slot_ch  [2];
    logic              oldest;

    // Writer state
    w_state_t          w_state;
    logic              wr_slot;
    logic [AW-1:0]     wr_ptr;
    logic [1:0]        wr_ch;

    // Reader state and output pipeline
    r_state_t          r_state;
    logic              rd_slot;
    logic [AW-1:0]     rd_len;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_d_p1;
    logic              vld_p1;
    logic              last_p1;
    logic [1:0]        ch_p1;

    // Writer combinational decode
    logic [16:0]       port_off;
    logic              port_ok;
    logic              free;
    logic              free_slot;
    logic              accept;
    logic              filling;
    logic              cur_slot;
    logic [AW-1:0]     cur_ptr;
    logic [1:0]        cur_ch;
    logic              we;
    logic [AW:0]       wr_cnt;
    logic              overflow;
    logic              commit;

    // Reader combinational decode
    logic [3:0]        rdy_ext;
    logic              xfer;
    logic              release_slot;
    logic              pick;

    // Port below PORT_BASE wraps to a large offset, so one compare covers both bounds
    assign port_off  = {1'b0, udp_port} - {1'b0, PORT_BASE};
    assign port_ok   = (port_off < 17'(NCH));
    assign free      = ~&full;
    assign free_slot = full[0];

    always_comb begin
        accept   = (w_state == W_IDLE) && udp_dv && port_ok && free;
        filling  = (w_state == W_FILL) || accept;
        cur_slot = accept ? free_slot : wr_slot;
        cur_ptr  = accept ? '0 : wr_ptr;
        cur_ch   = accept ? port_off[1:0] : wr_ch;
        we       = filling && udp_dv;
        wr_cnt   = {1'b0, cur_ptr} + (AW+1)'(we);
        // Writing at the last address would wrap the pointer: frame is oversize
        overflow = we && (&cur_ptr);
        commit   = filling && rx_end && udp_last && !overflow && (wr_cnt != '0);
    end

    // Writer FSM
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            wr_slot <= 1'b0;
            wr_ptr  <= '0;
            wr_ch   <= '0;
        end else if (filling) begin
            wr_slot <= cur_slot;
            wr_ch   <= cur_ch;
            wr_ptr  <= wr_cnt[AW-1:0];
            if (rx_end)        w_state <= W_IDLE;
            else if (overflow) w_state <= W_DROP;
            else               w_state <= W_FILL;
        end else begin
            case (w_state)
                W_DROP: if (rx_end) w_state <= W_IDLE;
                // Rejected first byte; a one-byte frame ending here is already over
                default: if (udp_dv && !rx_end) w_state <= W_DROP;
            endcase
        end
    end

    // Full flags: a release and a commit in the same cycle target different slots
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            full   <= '0;
            oldest <= 1'b0;
        end else begin
            if (release_slot) full[rd_slot] <= 1'b0;
            if (commit) begin
                full[cur_slot] <= 1'b1;
                // The new slot is oldest only if the other one will not hold a packet
                if (!(full[~cur_slot] && !(release_slot && (rd_slot == ~cur_slot))))
                    oldest <= cur_slot;
            end
        end
    end

    always_ff @(posedge c) begin
        if (commit) begin
            slot_len[cur_slot] <= wr_cnt[AW-1:0];
            slot_ch[cur_slot]  <= cur_ch;
        end
    end

    // Payload RAM, one-cycle registered read
    always_ff @(posedge c) begin
        if (we) ram[cur_slot][cur_ptr] <= udp_d;
        rd_d_p1 <= ram[rd_slot][rd_addr];
    end

    assign rdy_ext      = 4'(out_rdy);
    assign xfer         = vld_p1 && rdy_ext[ch_p1];
    assign release_slot = xfer && last_p1;
    assign pick         = (&full) ? oldest : full[1];
    // Re-reading the same address while stalled keeps out_d stable
    assign rd_addr      = rd_ptr + AW'(xfer);

    // Reader FSM; stage boundary: RAM read -> _p1 output registers
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rd_slot <= 1'b0;
            rd_len  <= '0;
            rd_ptr  <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            ch_p1   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (|full) begin
                        r_state <= R_SEND;
                        rd_slot <= pick;
                        rd_len  <= slot_len[pick];
                        ch_p1   <= slot_ch[pick];
                        rd_ptr  <= '0;
                    end
                end
                default: begin
                    if (!vld_p1) begin
                        // Byte 0 is being read on this edge
                        vld_p1  <= 1'b1;
                        last_p1 <= (rd_len == AW'(1));
                    end else if (xfer) begin
                        if (last_p1) begin
                            r_state <= R_IDLE;
                            vld_p1  <= 1'b0;
                            last_p1 <= 1'b0;
                        end else begin
                            rd_ptr  <= rd_ptr + AW'(1);
                            last_p1 <= (({1'b0, rd_ptr} + (AW+1)'(2)) == {1'b0, rd_len});
                        end
                    end
                end
            endcase
        end
    end

    assign out_dv   = vld_p1;
    assign out_last = last_p1;
    assign out_ch   = ch_p1;
    assign out_d    = vld_p1 ? rd_d_p1 : '0;

`ifdef UDP_RX_DISPATCH_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_q;

    // Every frame end that does not commit a slot is a discarded frame
    always_ff @(posedge c or posedge rst) begin
        if (rst)                  drop_q <= '0;
        else if (rx_end && !commit) drop_q <= sat_inc(drop_q);
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/udp_rx_dispatch.md
UDP_RX_DISPATCH -- requirements
Module: udp_rx_dispatch

Interface
REQ-001 SHALL have parameter PORT_BASE, default 16'd11300, which is the UDP destination port of channel 0; channel k listens on PORT_BASE+k.
REQ-002 SHALL have parameter NCH, default 4, giving the number of consumer channels; legal values are 1..4.
REQ-003 SHALL have port c, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port udp_d, input, 8 bits: the payload byte from the UDP receiver.
REQ-006 SHALL have port udp_dv, input, 1 bit: udp_d is valid this cycle.
REQ-007 SHALL have port udp_last, input, 1 bit: one-cycle strobe meaning the frame passed its FCS and length checks.
REQ-008 SHALL have port rx_end, input, 1 bit: one-cycle end-of-frame strobe for every frame, good or bad.
REQ-009 SHALL have port udp_port, input, 16 bits: the destination port, stable from the first udp_dv of a frame until rx_end.
REQ-010 SHALL have port out_rdy, input, NCH bits: consumer k can accept a byte.
REQ-011 SHALL have port out_d, output, 8 bits: the byte being dispatched.
REQ-012 SHALL have port out_dv, output, 1 bit: out_d is valid.
REQ-013 SHALL have port out_last, output, 1 bit: out_d is the final byte of its packet.
REQ-014 SHALL have port out_ch, output, 2 bits: the index of the destination channel.
REQ-015 SHALL have port drop_cnt, output, 16 bits: the number of discarded frames.

Function
REQ-016 SHALL buffer payloads in two RAM slots of 2048x8 bits each (ping-pong), with a 1-cycle read latency.
REQ-017 Writer FSM SHALL have three states:
- W_IDLE -> W_FILL on the first udp_dv when udp_port is in PORT_BASE..PORT_BASE+NCH-1 and a free slot exists.
- W_IDLE -> W_DROP on the first udp_dv otherwise.
REQ-018 In W_FILL the writer SHALL write each udp_dv byte at the slot write pointer and then increment the pointer, which is 11 bits wide.
REQ-019 When the write pointer would pass 2047, the writer SHALL go to W_DROP and the slot SHALL stay free.
REQ-020 On rx_end in W_FILL with udp_last in the same cycle, the writer SHALL commit the slot and return to W_IDLE.
- Commit sets the slot's full flag, stores its length (bytes written) and its channel (udp_port - PORT_BASE).
REQ-021 On rx_end in W_FILL without udp_last, the writer SHALL discard the slot (it stays free), increment the drop count and return to W_IDLE.
REQ-022 On rx_end in W_DROP, the writer SHALL increment the drop count and return to W_IDLE; udp_last is ignored in that state.
REQ-023 A committed packet of zero length SHALL be discarded and counted as a drop.
REQ-024 Reader FSM SHALL have two states, R_IDLE and R_SEND.
- R_IDLE -> R_SEND when a slot is full, choosing the oldest committed slot first.
REQ-025 In R_SEND, out_dv SHALL be high while bytes remain.
- A byte transfers on out_dv & out_rdy[out_ch]; the read pointer advances only on a transfer.
- out_d, out_ch and out_last stay stable while the transfer is stalled.
REQ-026 The first out_dv SHALL be asserted 2 cycles after the commit edge, given an idle reader.
REQ-027 On the transfer with out_last=1 the reader SHALL clear the slot's full flag and return to R_IDLE.
REQ-028 The release of a slot by the reader and a commit by the writer in the same cycle SHALL both take effect.
REQ-029 A freed slot SHALL be claimable by a frame starting on the next cycle.
REQ-030 out_dv SHALL never be asserted for a slot that is not full.
REQ-031 drop_cnt SHALL saturate at 16'hFFFF.
REQ-032 A frame with both slots full SHALL be dropped in its entirety and SHALL NOT stall the input.

Reset
REQ-033 rst SHALL set both FSMs to IDLE, clear both full flags, clear all pointers and set drop_cnt to 0.
REQ-034 After rst, out_dv=0, out_last=0, out_ch=0 and out_d=0.
REQ-035 A frame in progress when rst deasserts SHALL be treated as a new frame starting at its next udp_dv.

Configuration
REQ-036 The macro UDP_RX_DISPATCH_STATS_EN SHALL control the drop counter:
- Defined: the drop counter is implemented as specified above.
- Undefined: drop_cnt is tied to 16'd0 and no counter register is present.

Verification
REQ-037 Bench SHALL drive a 10-byte frame on port 11301 with udp_last, with out_rdy=4'hF.
- Required: 10 bytes out in order, out_ch=1, out_last on byte 10, first out_dv 2 cycles after the commit.
REQ-038 Bench SHALL drive a frame on port 9999.
- Required: no out_dv; drop_cnt increases by 1.
REQ-039 Bench SHALL drive a 20-byte frame on port 11300 whose rx_end comes without udp_last.
- Required: no output; drop_cnt=1; the slot is reusable by the next frame.
REQ-040 Bench SHALL hold out_rdy=0 and send three good frames.
- Required: the first two are buffered and the third is dropped; after out_rdy=4'hF, frames 1 and 2 emerge in order and drop_cnt=1.
REQ-041 Bench SHALL toggle out_rdy[2] every cycle during a 64-byte packet on channel 2.
- Required: exactly 64 transfers; data is held stable during stalls.
REQ-042 Bench SHALL assert rst midway through readout.
- Required: out_dv=0 in the same cycle; both slots empty; drop_cnt=0.
